hyperbus_rx_packer: RTL and testbench

Read-data return path for the HyperBus uDMA channel. It accepts one read-transaction descriptor (byte length, start-address parity), consumes the 16-bit words the PHY returns, and packs them little-endian into 32-bit words for the uDMA RX FIFO. It drops the leading pad byte of a non-aligned read and zero-pads the final partial word. It sits between the PHY read port and the RX FIFO, beside the transaction controller that launches the read.

---
 rtl/hyperbus_rx_packer.sv | 204 ++++++++++++++++++++
 tb/tb_hyperbus_rx_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_rx_packer.sv
// HyperBus read-data packer: turns the PHY's 16-bit read words into little-endian
// 32-bit words for the uDMA RX FIFO, dropping the non-aligned pad byte and zero-padding the tail.
module hyperbus_rx_packer #(
    parameter int TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [TRANS_SIZE-1:0] cfg_size_i,
    input  logic                  cfg_na_i,
    input  logic [15:0]           rx_phy_data_i,
    input  logic                  rx_phy_valid_i,
    output logic                  rx_phy_ready_o,
    output logic [31:0]           rx_fifo_data_o,
    output logic [2:0]            rx_fifo_bytes_o,
    output logic                  rx_fifo_valid_o,
    input  logic                  rx_fifo_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  init_q, init_d;
    logic [TRANS_SIZE-1:0] bytes_left_q, bytes_left_d;
    logic [TRANS_SIZE:0]   words_left_q, words_left_d;
    logic                  drop_q, drop_d;
    logic [23:0]           acc_q, acc_d;
    logic [1:0]            acc_cnt_q, acc_cnt_d;
    logic [31:0]           out_data_q, out_data_d;
    logic [2:0]            out_bytes_q, out_bytes_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  zero_q, zero_d;
    logic                  zero_arm_q, zero_arm_d;

    logic                  out_free;
    logic                  phy_hs;
    logic                  fifo_hs;
    logic                  last_word;
    logic [TRANS_SIZE:0]   wsum;
    logic [15:0]           nb;
    logic [1:0]            n;
    logic [2:0]            sum;
    logic [39:0]           comb;

    always_comb begin
        state_d      = state_q;
        init_d       = 1'b0;
        bytes_left_d = bytes_left_q;
        words_left_d = words_left_q;
        drop_d       = drop_q;
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        zero_d       = zero_q;
        zero_arm_d   = zero_arm_q;

        // init_q masks cfg_ready_o for the first cycle after reset releases
        cfg_ready_o    = (state_q == IDLE) && !init_q && !rst_i;
        out_free       = !out_valid_q || rx_fifo_ready_i;
        rx_phy_ready_o = (state_q == RUN) && (words_left_q != '0) && out_free && !rst_i;
        phy_hs         = rx_phy_valid_i && rx_phy_ready_o;
        fifo_hs        = out_valid_q && rx_fifo_ready_i;
        done_o         = ((fifo_hs && out_last_q) || ((state_q == RUN) && zero_arm_q)) && !rst_i;
        last_word      = (words_left_q == (TRANS_SIZE+1)'(1));

        wsum = {1'b0, cfg_size_i} + (TRANS_SIZE+1)'(cfg_na_i) + (TRANS_SIZE+1)'(1);

        if (drop_q) begin
            nb = {8'd0, rx_phy_data_i[15:8]};
            n  = 2'd1;
        end else if (bytes_left_q == TRANS_SIZE'(1)) begin
            nb = {8'd0, rx_phy_data_i[7:0]};
            n  = 2'd1;
        end else begin
            nb = rx_phy_data_i;
            n  = 2'd2;
        end
        sum  = 3'(acc_cnt_q) + 3'(n);
        comb = {16'd0, acc_q} | ({24'd0, nb} << {acc_cnt_q, 3'b000});

        if (fifo_hs) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    bytes_left_d = cfg_size_i;
                    drop_d       = cfg_na_i;
                    words_left_d = wsum >> 1;
                    acc_d        = '0;
                    acc_cnt_d    = '0;
                    zero_d       = (cfg_size_i == '0);
                    zero_arm_d   = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // zero-length: one idle RUN cycle, then done in the next
                if (zero_q) begin
                    zero_d     = 1'b0;
                    zero_arm_d = 1'b1;
                end
                if (zero_arm_q) begin
                    zero_arm_d = 1'b0;
                    state_d    = IDLE;
                end
                if (phy_hs) begin
                    words_left_d = words_left_q - (TRANS_SIZE+1)'(1);
                    bytes_left_d = bytes_left_q - TRANS_SIZE'(n);
                    drop_d       = 1'b0;
                    if (sum >= 3'd4) begin
                        out_data_d  = comb[31:0];
                        out_bytes_d = 3'd4;
                        out_valid_d = 1'b1;
                        out_last_d  = last_word && (sum == 3'd4);
                        acc_d       = {16'd0, comb[39:32]};
                        acc_cnt_d   = 2'(sum - 3'd4);
                        if (last_word && (sum != 3'd4)) begin
                            state_d = FLUSH;
                        end
                    end else if (last_word) begin
                        out_data_d  = comb[31:0];
                        out_bytes_d = sum;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        acc_d       = '0;
                        acc_cnt_d   = '0;
                    end else begin
                        acc_d     = comb[23:0];
                        acc_cnt_d = sum[1:0];
                    end
                end
                if (fifo_hs && out_last_q) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // the leftover byte waits here until the previous full word drains
                if ((acc_cnt_q != '0) && out_free) begin
                    out_data_d  = {24'd0, acc_q[7:0]};
                    out_bytes_d = 3'd1;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    acc_cnt_d   = '0;
                end
                if (fifo_hs && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            init_q       <= 1'b1;
            bytes_left_q <= '0;
            words_left_q <= '0;
            drop_q       <= 1'b0;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            out_data_q   <= '0;
            out_bytes_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            zero_q       <= 1'b0;
            zero_arm_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            bytes_left_q <= bytes_left_d;
            words_left_q <= words_left_d;
            drop_q       <= drop_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            zero_q       <= zero_d;
            zero_arm_q   <= zero_arm_d;
        end
    end

    assign rx_fifo_data_o  = out_data_q;
    assign rx_fifo_bytes_o = out_bytes_q;
    assign rx_fifo_valid_o = out_valid_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_hyperbus_rx_packer.sv
// Directed bench for hyperbus_rx_packer: expected FIFO words are queued as each
// case is set up and compared as the DUT hands them out.
module tb_hyperbus_rx_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [15:0] cfg_size_i = '0;
    logic        cfg_na_i = 1'b0;
    logic [15:0] rx_phy_data_i = '0;
    logic        rx_phy_valid_i = 1'b0;
    logic        rx_phy_ready_o;
    logic [31:0] rx_fifo_data_o;
    logic [2:0]  rx_fifo_bytes_o;
    logic        rx_fifo_valid_o;
    logic        rx_fifo_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int phy_hs = 0;
    int base_d, base_p;
    logic [34:0] exp_q[$];
    logic [34:0] e;

    always #5 clk_i = ~clk_i;

    hyperbus_rx_packer #(.TRANS_SIZE(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_size_i(cfg_size_i), .cfg_na_i(cfg_na_i),
        .rx_phy_data_i(rx_phy_data_i), .rx_phy_valid_i(rx_phy_valid_i),
        .rx_phy_ready_o(rx_phy_ready_o),
        .rx_fifo_data_o(rx_fifo_data_o), .rx_fifo_bytes_o(rx_fifo_bytes_o),
        .rx_fifo_valid_o(rx_fifo_valid_o), .rx_fifo_ready_i(rx_fifo_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1, so negedge sees the values the next edge will sample.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rx_phy_valid_i && rx_phy_ready_o) phy_hs++;
            if (done_o) done_cnt++;
            if (rx_fifo_valid_o && rx_fifo_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("fifo_extra_word", 35'(exp_q.size()), 35'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_word", {rx_fifo_bytes_o, rx_fifo_data_o}, e);
                end
            end
        end
    end

    task automatic do_cfg(input logic [15:0] sz, input logic na);
        int t = 0;
        cfg_size_i  = sz;
        cfg_na_i    = na;
        cfg_valid_i = 1'b1;
        @(negedge clk_i);
        while (!cfg_ready_o && t < 100) begin t++; @(negedge clk_i); end
        chk("cfg_ready_wait", 35'(cfg_ready_o), 35'd1);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
    endtask

    task automatic phy_send(input logic [15:0] w);
        int t = 0;
        rx_phy_data_i  = w;
        rx_phy_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_phy_ready_o && t < 100) begin t++; @(negedge clk_i); end
        chk("phy_ready_wait", 35'(rx_phy_ready_o), 35'd1);
        @(posedge clk_i); #1;
        rx_phy_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int phy_exp);
        int t = 0;
        @(negedge clk_i);
        while (done_cnt < target && t < 200) begin t++; @(negedge clk_i); end
        repeat (3) @(negedge clk_i);
        chk({tag, "_done_once"}, 35'(done_cnt), 35'(target));
        chk({tag, "_phy_hs"}, 35'(phy_hs - base_p), 35'(phy_exp));
        chk({tag, "_queue_empty"}, 35'(exp_q.size()), 35'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_data", {rx_fifo_bytes_o, rx_fifo_data_o}, 35'd0);
        chk("rst_flags", 35'({cfg_ready_o, rx_phy_ready_o, rx_fifo_valid_o, busy_o, done_o}), 35'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("cfg_ready_first_cycle", 35'(cfg_ready_o), 35'd0);
        @(negedge clk_i);
        chk("cfg_ready_rises", 35'(cfg_ready_o), 35'd1);
        @(posedge clk_i); #1;

        // aligned read
        rx_fifo_ready_i = 1'b1;
        base_d = done_cnt; base_p = phy_hs;
        exp_q.push_back({3'd4, 32'h44332211});
        exp_q.push_back({3'd4, 32'h88776655});
        do_cfg(16'd8, 1'b0);
        phy_send(16'h2211); phy_send(16'h4433); phy_send(16'h6655); phy_send(16'h8877);
        wait_done("t1", base_d + 1, 4);

        // non-aligned read
        base_d = done_cnt; base_p = phy_hs;
        exp_q.push_back({3'd4, 32'h44332211});
        do_cfg(16'd4, 1'b1);
        phy_send(16'h11AA); phy_send(16'h3322); phy_send(16'hBB44);
        wait_done("t2", base_d + 1, 3);

        // odd tail, aligned
        base_d = done_cnt; base_p = phy_hs;
        exp_q.push_back({3'd3, 32'h00332211});
        do_cfg(16'd3, 1'b0);
        phy_send(16'h2211); phy_send(16'hCC33);
        wait_done("t3a", base_d + 1, 2);

        // odd tail with flush byte
        base_d = done_cnt; base_p = phy_hs;
        exp_q.push_back({3'd4, 32'h44332211});
        exp_q.push_back({3'd1, 32'h00000055});
        do_cfg(16'd5, 1'b1);
        phy_send(16'h11AA); phy_send(16'h3322); phy_send(16'h5544);
        wait_done("t3b", base_d + 1, 3);

        // backpressure
        base_d = done_cnt; base_p = phy_hs;
        rx_fifo_ready_i = 1'b0;
        exp_q.push_back({3'd4, 32'h44332211});
        exp_q.push_back({3'd4, 32'h88776655});
        do_cfg(16'd8, 1'b0);
        fork
            begin : send_b
                phy_send(16'h2211); phy_send(16'h4433); phy_send(16'h6655); phy_send(16'h8877);
            end
            begin : stall_b
                int t = 0;
                logic seen = 1'b0;
                @(negedge clk_i);
                while (!rx_fifo_valid_o && t < 100) begin t++; @(negedge clk_i); end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    if (!rx_phy_ready_o) seen = 1'b1;
                end
                chk("t4_phy_stalled", 35'(seen), 35'd1);
                @(posedge clk_i); #1;
                rx_fifo_ready_i = 1'b1;
            end
        join
        wait_done("t4", base_d + 1, 4);

        // zero-length
        base_d = done_cnt; base_p = phy_hs;
        rx_phy_data_i  = 16'hDEAD;
        rx_phy_valid_i = 1'b1;
        do_cfg(16'd0, 1'b0);
        @(negedge clk_i);
        chk("t5_done_c1", 35'(done_o), 35'd0);
        @(negedge clk_i);
        chk("t5_done_c2", 35'(done_o), 35'd1);
        @(negedge clk_i);
        chk("t5_cfg_ready_back", 35'(cfg_ready_o), 35'd1);
        @(posedge clk_i); #1;
        rx_phy_valid_i = 1'b0;
        wait_done("t5", base_d + 1, 0);

        // reset mid-transfer, then a clean non-aligned read
        rx_fifo_ready_i = 1'b0;
        do_cfg(16'd8, 1'b0);
        phy_send(16'h2211); phy_send(16'h4433);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("t6_rst_data", {rx_fifo_bytes_o, rx_fifo_data_o}, 35'd0);
        chk("t6_rst_flags", 35'({cfg_ready_o, rx_phy_ready_o, rx_fifo_valid_o, busy_o, done_o}), 35'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rx_fifo_ready_i = 1'b1;
        base_d = done_cnt; base_p = phy_hs;
        exp_q.push_back({3'd4, 32'h44332211});
        do_cfg(16'd4, 1'b1);
        phy_send(16'h11AA); phy_send(16'h3322); phy_send(16'hBB44);
        wait_done("t6", base_d + 1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
